// File: rtl/message_dispatcher.sv
// Routes execute-stage requests into one of two independent FIFOs (post office
// or mailbox); each FIFO presents its head entry on a valid/ready channel.

module dispatcher_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop_ready,
    output logic                       valid,
    output logic [DATA_W-1:0]          data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    // Flush and reset freeze both ends of the queue before the clear takes effect.
    assign do_push = push && !rst && !flush;
    assign do_pop  = valid && pop_ready && !rst && !flush;

    assign valid = (count_q != '0);
    assign data  = mem[rd_ptr];
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    // Storage is unreset; the head is only observed while valid is high.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

module message_dispatcher #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       ex_dispatcher_valid,
    input  logic                       ex_dispatcher_is_send,
    input  logic [DATA_W-1:0]          ex_dispatcher_data,
    output logic                       dispatcher_ex_ready,
    output logic                       dispatcher_postoffice_valid,
    input  logic                       postoffice_dispatcher_ready,
    output logic [DATA_W-1:0]          dispatcher_postoffice_data,
    output logic                       dispatcher_mailbox_valid,
    input  logic                       mailbox_dispatcher_ready,
    output logic [DATA_W-1:0]          dispatcher_mailbox_data,
    output logic [$clog2(DEPTH):0]     dispatcher_postoffice_count,
    output logic [$clog2(DEPTH):0]     dispatcher_mailbox_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Handshake: a transfer happens on any cycle where valid and ready are both
    // high; ready never looks at valid, and valid never looks at ready.
    logic [CW-1:0] sel_count;
    logic          push_po;
    logic          push_mb;

    // A full queue refuses a push even if it pops this cycle (no pass-through).
    assign sel_count           = ex_dispatcher_is_send ? dispatcher_postoffice_count
                                                       : dispatcher_mailbox_count;
    assign dispatcher_ex_ready = !rst && !flush && (sel_count < CW'(DEPTH));
    assign push_po = ex_dispatcher_valid && dispatcher_ex_ready && ex_dispatcher_is_send;
    assign push_mb = ex_dispatcher_valid && dispatcher_ex_ready && !ex_dispatcher_is_send;

    dispatcher_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_postoffice_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push_po),
        .push_data (ex_dispatcher_data),
        .pop_ready (postoffice_dispatcher_ready),
        .valid     (dispatcher_postoffice_valid),
        .data      (dispatcher_postoffice_data),
        .count     (dispatcher_postoffice_count)
    );

    dispatcher_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mailbox_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push_mb),
        .push_data (ex_dispatcher_data),
        .pop_ready (mailbox_dispatcher_ready),
        .valid     (dispatcher_mailbox_valid),
        .data      (dispatcher_mailbox_data),
        .count     (dispatcher_mailbox_count)
    );
endmodule

// File: tb/tb_message_dispatcher.sv
// Directed bench for message_dispatcher: a queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.

module tb_message_dispatcher;
    localparam int W     = 64;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          ex_valid = 1'b0;
    logic          ex_is_send = 1'b0;
    logic [W-1:0]  ex_data = '0;
    logic          ex_ready;
    logic          po_valid, po_ready = 1'b0;
    logic [W-1:0]  po_data;
    logic          mb_valid, mb_ready = 1'b0;
    logic [W-1:0]  mb_data;
    logic [CW-1:0] po_count, mb_count;

    int checks = 0;
    int failures = 0;
    bit checking = 1'b0;

    logic [W-1:0] po_q[$];
    logic [W-1:0] mb_q[$];
    logic [W-1:0] po_log[$];

    message_dispatcher #(.DATA_W(W), .DEPTH(DEPTH)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .flush                       (flush),
        .ex_dispatcher_valid         (ex_valid),
        .ex_dispatcher_is_send       (ex_is_send),
        .ex_dispatcher_data          (ex_data),
        .dispatcher_ex_ready         (ex_ready),
        .dispatcher_postoffice_valid (po_valid),
        .postoffice_dispatcher_ready (po_ready),
        .dispatcher_postoffice_data  (po_data),
        .dispatcher_mailbox_valid    (mb_valid),
        .mailbox_dispatcher_ready    (mb_ready),
        .dispatcher_mailbox_data     (mb_data),
        .dispatcher_postoffice_count (po_count),
        .dispatcher_mailbox_count    (mb_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: queue semantics applied at each rising edge
    always @(posedge clk) begin
        int sel_size;
        bit acc, pop_po, pop_mb;
        if (rst || flush) begin
            po_q.delete();
            mb_q.delete();
        end else begin
            sel_size = ex_is_send ? po_q.size() : mb_q.size();
            acc    = ex_valid && (sel_size < DEPTH);
            pop_po = (po_q.size() > 0) && po_ready;
            pop_mb = (mb_q.size() > 0) && mb_ready;
            if (pop_po) po_log.push_back(po_q.pop_front());
            if (pop_mb) void'(mb_q.pop_front());
            if (acc && ex_is_send)  po_q.push_back(ex_data);
            if (acc && !ex_is_send) mb_q.push_back(ex_data);
        end
    end

    // per-cycle comparison away from the active edge
    always @(negedge clk) begin
        if (checking) begin
            check("ready", W'(ex_ready),
                  W'(!rst && !flush && ((ex_is_send ? po_q.size() : mb_q.size()) < DEPTH)));
            check("po_count", W'(po_count), W'(po_q.size()));
            check("mb_count", W'(mb_count), W'(mb_q.size()));
            check("po_valid", W'(po_valid), W'(po_q.size() > 0));
            check("mb_valid", W'(mb_valid), W'(mb_q.size() > 0));
            if (po_q.size() > 0) check("po_data", po_data, po_q[0]);
            if (mb_q.size() > 0) check("mb_data", mb_data, mb_q[0]);
        end
    end

    // driver: apply inputs for one cycle, return #1 after the edge
    task automatic cyc(input bit v, input bit s, input logic [W-1:0] d,
                       input bit por, input bit mbr, input bit fl, input bit r);
        ex_valid = v; ex_is_send = s; ex_data = d;
        po_ready = por; mb_ready = mbr; flush = fl; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_only(input bit v, input bit s, input logic [W-1:0] d,
                              input bit por, input bit mbr, input bit fl, input bit r);
        ex_valid = v; ex_is_send = s; ex_data = d;
        po_ready = por; mb_ready = mbr; flush = fl; rst = r;
        #1;
    endtask

    initial begin
        cyc(1, 1, 64'h99, 0, 0, 0, 1);
        checking = 1'b1;
        drive_only(1, 1, 64'h99, 1, 1, 0, 1);
        check("rst_ready", W'(ex_ready), W'(0));
        cyc(1, 1, 64'h99, 1, 1, 0, 1);
        check("rst_po_count", W'(po_count), W'(0));
        check("rst_mb_count", W'(mb_count), W'(0));
        check("rst_po_valid", W'(po_valid), W'(0));
        check("rst_mb_valid", W'(mb_valid), W'(0));

        // single send, one-cycle latency
        cyc(1, 1, 64'hA5, 1, 0, 0, 0);
        check("send_po_valid", W'(po_valid), W'(1));
        check("send_po_data", po_data, 64'hA5);
        check("send_po_count", W'(po_count), W'(1));
        check("send_mb_valid", W'(mb_valid), W'(0));
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("send_drain_count", W'(po_count), W'(0));

        // mailbox fill then drain
        cyc(1, 0, 64'h1, 0, 0, 0, 0);
        cyc(1, 0, 64'h2, 0, 0, 0, 0);
        drive_only(1, 0, 64'h3, 0, 0, 0, 0);
        check("fill_ready_low", W'(ex_ready), W'(0));
        @(posedge clk); #1;
        check("fill_count", W'(mb_count), W'(2));
        check("fill_head", mb_data, 64'h1);
        cyc(1, 0, 64'h3, 0, 1, 0, 0);
        check("fill_pop1_head", mb_data, 64'h2);
        check("fill_pop1_count", W'(mb_count), W'(1));
        cyc(1, 0, 64'h3, 0, 1, 0, 0);
        check("fill_accept3_head", mb_data, 64'h3);
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("fill_empty", W'(mb_count), W'(0));

        // full post office popping while a mailbox push lands
        cyc(1, 1, 64'h10, 0, 0, 0, 0);
        cyc(1, 1, 64'h11, 0, 0, 0, 0);
        drive_only(1, 1, 64'h12, 1, 0, 0, 0);
        check("full_ready_low", W'(ex_ready), W'(0));
        drive_only(1, 0, 64'h20, 1, 0, 0, 0);
        check("full_mb_ready", W'(ex_ready), W'(1));
        @(posedge clk); #1;
        check("full_po_count", W'(po_count), W'(1));
        check("full_po_head", po_data, 64'h11);
        check("full_mb_count", W'(mb_count), W'(1));
        check("full_mb_head", mb_data, 64'h20);
        cyc(0, 0, 0, 1, 1, 0, 0);

        // wrap: streamed push/pop of 0..7 through the post office
        po_log.delete();
        for (int i = 0; i < 8; i++) cyc(1, 1, W'(i), 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("wrap_log_size", W'(po_log.size()), W'(8));
        for (int i = 0; i < 8; i++)
            if (i < po_log.size()) check("wrap_order", po_log[i], W'(i));

        // flush with both queues full
        cyc(1, 1, 64'hB0, 0, 0, 0, 0);
        cyc(1, 1, 64'hB1, 0, 0, 0, 0);
        cyc(1, 0, 64'hC0, 0, 0, 0, 0);
        cyc(1, 0, 64'hC1, 0, 0, 0, 0);
        drive_only(1, 0, 64'hC2, 1, 1, 1, 0);
        check("flush_ready", W'(ex_ready), W'(0));
        @(posedge clk); #1;
        check("flush_po_count", W'(po_count), W'(0));
        check("flush_mb_count", W'(mb_count), W'(0));
        check("flush_po_valid", W'(po_valid), W'(0));
        check("flush_mb_valid", W'(mb_valid), W'(0));

        // reset mid-stream, then first push after release
        cyc(1, 1, 64'h30, 0, 0, 0, 0);
        cyc(1, 0, 64'h40, 0, 0, 0, 0);
        cyc(1, 0, 64'h41, 0, 0, 0, 0);
        check("pre_rst_counts", W'({po_count, mb_count}), W'({CW'(1), CW'(2)}));
        cyc(1, 1, 64'h42, 1, 1, 0, 1);
        check("mid_rst_po_count", W'(po_count), W'(0));
        check("mid_rst_mb_count", W'(mb_count), W'(0));
        check("mid_rst_valids", W'({po_valid, mb_valid}), W'(0));
        cyc(1, 1, 64'h50, 0, 0, 0, 0);
        check("post_rst_po_valid", W'(po_valid), W'(1));
        check("post_rst_po_data", po_data, 64'h50);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
